// File: rtl/nios_oci_dct_pkg.sv
// Shared definitions for the OCI compressed-trace (DCT) packer: default frame
// geometry, accumulator state encoding and the word handed to the trace sink.
package nios_oci_dct_pkg;

    localparam int DCT_FRAME_W = 2;
    localparam int DCT_FRAMES  = 15;
    localparam int DCT_CNT_W   = 4;
    localparam int DCT_BUF_W   = DCT_FRAME_W * DCT_FRAMES;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } acc_state_e;

    typedef struct packed {
        logic [DCT_BUF_W-1:0] buffer;
        logic [DCT_CNT_W-1:0] count;
    } dct_word_t;

endpackage

// File: rtl/nios_oci_dct_out_slot.sv
// Single-entry valid/ready output register for packed DCT words; the word is
// held stable while the consumer stalls and may be replaced in the drain cycle.
module nios_oci_dct_out_slot
    import nios_oci_dct_pkg::*;
#(
    parameter type word_t = dct_word_t
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  word_t load_word,
    input  logic  out_ready,
    output logic  free,
    output logic  out_valid,
    output word_t word
);

    logic  valid_q, valid_d;
    word_t word_q, word_d;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        free    = !valid_q || out_ready;
        if (load) begin
            valid_d = 1'b1;
            word_d  = load_word;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the held word is reset too, because the sink observes dct_buffer/dct_count as zero out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    assign out_valid = valid_q;
    assign word      = word_q;

endmodule

// File: rtl/nios_oci_dct_packer.sv
// Packs 2-bit trace codes into 30-bit dct_buffer words with a frame count.
// Build option NIOS_OCI_DCT_DROP_CNT_EN: never backpressure, count dropped codes instead.
module nios_oci_dct_packer
    import nios_oci_dct_pkg::*;
#(
    parameter int FRAME_W = DCT_FRAME_W,
    parameter int FRAMES  = DCT_FRAMES,
    parameter int CNT_W   = DCT_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [FRAME_W-1:0]         in_code,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FRAME_W*FRAMES-1:0]  dct_buffer,
    output logic [CNT_W-1:0]           dct_count,
`ifdef NIOS_OCI_DCT_DROP_CNT_EN
    output logic [15:0]                drop_count,
    output logic                       overflow,
`endif
    output logic [15:0]                words_out
);

    localparam int BUF_W = FRAME_W * FRAMES;

    typedef struct packed {
        logic [BUF_W-1:0] buffer;
        logic [CNT_W-1:0] count;
    } word_t;

    logic [BUF_W-1:0] acc_buf_q, acc_buf_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    acc_state_e       state_q, state_d;
    logic             flush_pend_q, flush_pend_d;
    logic [15:0]      words_out_q, words_out_d;

    logic  slot_free;
    logic  xfer;
    logic  accept;
    logic  can_store;
    word_t slot_word;

`ifdef NIOS_OCI_DCT_DROP_CNT_EN
    logic [15:0] drop_count_q, drop_count_d;
    logic        overflow_q, overflow_d;
    logic        drop;
`endif

    always_comb begin
        // A word leaves when the accumulator is full or a pending flush has frames to send.
        xfer      = ((state_q == ST_FULL) || (flush_pend_q && (state_q != ST_EMPTY))) && slot_free;
        can_store = (state_q != ST_FULL) || xfer;
        accept    = in_valid && can_store;
`ifdef NIOS_OCI_DCT_DROP_CNT_EN
        in_ready  = 1'b1;
        drop      = in_valid && !can_store;
`else
        in_ready  = can_store;
`endif
    end

    always_comb begin
        acc_buf_d    = acc_buf_q;
        acc_cnt_d    = acc_cnt_q;
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        words_out_d  = words_out_q;

        if (xfer) begin
            words_out_d = words_out_q + 16'd1;
            if (accept) begin
                // The frame arriving with a transfer starts the next word.
                acc_buf_d = {{(BUF_W-FRAME_W){1'b0}}, in_code};
                acc_cnt_d = CNT_W'(1);
                state_d   = ST_FILLING;
            end else begin
                acc_buf_d = '0;
                acc_cnt_d = '0;
                state_d   = ST_EMPTY;
            end
        end else if (accept) begin
            acc_buf_d = {acc_buf_q[BUF_W-FRAME_W-1:0], in_code};
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
            state_d   = (acc_cnt_q == CNT_W'(FRAMES - 1)) ? ST_FULL : ST_FILLING;
        end

        if (xfer) begin
            flush_pend_d = 1'b0;
        end else if ((state_q == ST_EMPTY) && !accept) begin
            flush_pend_d = 1'b0;
        end else begin
            flush_pend_d = flush_pend_q || flush;
        end
    end

`ifdef NIOS_OCI_DCT_DROP_CNT_EN
    always_comb begin
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q || drop;
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_buf_q    <= '0;
            acc_cnt_q    <= '0;
            state_q      <= ST_EMPTY;
            flush_pend_q <= 1'b0;
            words_out_q  <= '0;
        end else begin
            acc_buf_q    <= acc_buf_d;
            acc_cnt_q    <= acc_cnt_d;
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            words_out_q  <= words_out_d;
        end
    end

    nios_oci_dct_out_slot #(
        .word_t (word_t)
    ) u_out_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (xfer),
        .load_word ('{buffer: acc_buf_q, count: acc_cnt_q}),
        .out_ready (out_ready),
        .free      (slot_free),
        .out_valid (out_valid),
        .word      (slot_word)
    );

    assign dct_buffer = slot_word.buffer;
    assign dct_count  = slot_word.count;
    assign words_out  = words_out_q;

endmodule

// File: tb/tb_nios_oci_dct_packer.sv
// Bench for nios_oci_dct_packer: a frame-list model predicts every emitted word,
// directed scenarios pin latency, flush, backpressure and reset behaviour.
module tb_nios_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_code;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [15:0] words_out;
`ifdef NIOS_OCI_DCT_DROP_CNT_EN
    logic [15:0] drop_count;
    logic        overflow;
`endif

    nios_oci_dct_packer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
`ifdef NIOS_OCI_DCT_DROP_CNT_EN
        .drop_count (drop_count),
        .overflow   (overflow),
`endif
        .words_out  (words_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: frames accepted so far, and the words they must form, oldest first.
    typedef struct {
        bit [29:0] bufv;
        bit [3:0]  cnt;
    } exp_t;

    bit [1:0] model_acc[$];
    exp_t     exp_q[$];
    bit       model_en = 1'b1;
    bit       hold_prev = 1'b0;
    bit [29:0] prev_buf;
    bit [3:0]  prev_cnt;

    function automatic exp_t pack(input bit [1:0] codes[$]);
        exp_t e;
        e.bufv = '0;
        foreach (codes[i]) e.bufv = (e.bufv << 2) | 30'(codes[i]);
        e.cnt = 4'(codes.size());
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            model_acc.delete();
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_buffer", dct_buffer, prev_buf);
                check("hold_count", dct_count, prev_cnt);
            end
            if (out_valid && out_ready) begin
                check("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word_buffer", dct_buffer, e.bufv);
                    check("word_count", dct_count, e.cnt);
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_buf  = dct_buffer;
            prev_cnt  = dct_count;
            if (model_en) begin
                if (in_valid && in_ready) model_acc.push_back(in_code);
                if (model_acc.size() == 15 || (flush && model_acc.size() != 0)) begin
                    exp_q.push_back(pack(model_acc));
                    model_acc.delete();
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input bit [1:0] c, input bit fl = 1'b0);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_code  = c;
        flush    = fl;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        check("send_accepted", ok, 1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_code   = 2'd0;
        flush     = 1'b0;
        out_ready = 1'b1;
        step(3);
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_dct_buffer", dct_buffer, 0);
        check("rst_dct_count", dct_count, 0);
        check("rst_words_out", words_out, 0);
        check("rst_in_ready", in_ready, 1);

        // Full word, streamed back-to-back: out_valid two cycles after last accept.
        for (int i = 0; i < 15; i++) send(2'(i % 4));
        idle();
        check("t1_not_yet_valid", out_valid, 0);
        step();
        check("t1_out_valid", out_valid, 1);
        check("t1_buffer", dct_buffer, 30'h06C6C6C6);
        check("t1_count", dct_count, 15);
        check("t1_words_out", words_out, 1);
        step();
        check("t1_drained", out_valid, 0);

        // Partial word by flush, then a flush with nothing accumulated.
        for (int i = 0; i < 3; i++) send(2'd3);
        send(2'd3, 1'b1);
        idle();
        step();
        check("t2_out_valid", out_valid, 1);
        check("t2_buffer", dct_buffer, 30'h000000FF);
        check("t2_count", dct_count, 4);
        check("t2_words_out", words_out, 2);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step(3);
        check("t2_empty_flush_valid", out_valid, 0);
        check("t2_empty_flush_words", words_out, 2);

        // Flush in the same cycle as the seventh frame.
        send(2'd1); send(2'd2); send(2'd3); send(2'd1); send(2'd2); send(2'd3);
        send(2'd0, 1'b1);
        idle();
        step();
        check("t4_out_valid", out_valid, 1);
        check("t4_count", dct_count, 7);
        check("t4_buffer", dct_buffer, 30'h00001B6C);
        check("t4_words_out", words_out, 3);
        step();

`ifndef NIOS_OCI_DCT_DROP_CNT_EN
        // Backpressure: two words stacked, 31st offer stalls until the drain cycle.
        out_ready = 1'b0;
        for (int i = 0; i < 30; i++) send(2'(i % 4));
        in_valid = 1'b1;
        in_code  = 2'd2;
        @(negedge clk);
        check("t3_stall_ready", in_ready, 0);
        check("t3_word1_valid", out_valid, 1);
        check("t3_word1_buffer", dct_buffer, 30'h06C6C6C6);
        check("t3_word1_count", dct_count, 15);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t3_still_stalled", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_ready_on_drain", in_ready, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("t3_word2_valid", out_valid, 1);
        check("t3_word2_count", dct_count, 15);
        check("t3_words_out", words_out, 5);
        out_ready = 1'b1;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check("t3_tail_valid", out_valid, 1);
        check("t3_tail_count", dct_count, 1);
        check("t3_tail_buffer", dct_buffer, 30'h00000002);
        check("t3_tail_words_out", words_out, 6);
        step();
`else
        // Drop mode: no backpressure, overflow frames are counted and discarded.
        begin
            bit [1:0] kept[$];
            model_en  = 1'b0;
            out_ready = 1'b0;
            for (int i = 0; i < 40; i++) send(2'(i % 4));
            idle();
            check("d_in_ready", in_ready, 1);
            check("d_drop_count", drop_count, 10);
            check("d_overflow", overflow, 1);
            for (int i = 0; i < 15; i++) kept.push_back(2'(i % 4));
            exp_q.push_back(pack(kept));
            kept.delete();
            for (int i = 15; i < 30; i++) kept.push_back(2'(i % 4));
            exp_q.push_back(pack(kept));
            out_ready = 1'b1;
            step(4);
            check("d_words_out", words_out, 5);
            check("d_overflow_sticky", overflow, 1);
            model_en = 1'b1;
        end
`endif
        check("queue_drained", exp_q.size(), 0);
        check("model_acc_empty", model_acc.size(), 0);

        // Reset mid-word with a word parked in the output slot.
        out_ready = 1'b0;
        for (int i = 0; i < 24; i++) send(2'(i % 4));
        idle();
        check("t5_pre_valid", out_valid, 1);
        reset = 1'b1;
        step();
        check("t5_out_valid", out_valid, 0);
        check("t5_dct_count", dct_count, 0);
        check("t5_dct_buffer", dct_buffer, 0);
        check("t5_words_out", words_out, 0);
        check("t5_in_ready", in_ready, 1);
        reset     = 1'b0;
        out_ready = 1'b1;
        step();

        // Clean word after reset: nothing from before the reset leaks out.
        for (int i = 0; i < 15; i++) send(2'd3);
        idle();
        step();
        check("t6_out_valid", out_valid, 1);
        check("t6_buffer", dct_buffer, 30'h3FFFFFFF);
        check("t6_words_out", words_out, 1);
        step(2);
        check("final_queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
